// File: rtl/reset_sequencer.sv
// Reset sequencer: async-assert/sync-release front end, POR hold,
// staggered per-channel release and software-requested reset hold.
module reset_sequencer #(
  parameter int POR_CYCLES     = 1000,
  parameter int N_CH           = 3,
  parameter int STAGE_CYCLES   = 16,
  parameter int SW_HOLD_CYCLES = 64,
  parameter int SYNC_STAGES    = 2
) (
  input  logic            clk,
  input  logic            rst_in,
  input  logic            sw_rst_req,
  output logic [N_CH-1:0] rst_out,
  output logic            ready
);

  localparam int MAX_A = (POR_CYCLES > STAGE_CYCLES)
                       ? POR_CYCLES : STAGE_CYCLES;
  localparam int MAX_C = (MAX_A > SW_HOLD_CYCLES)
                       ? MAX_A : SW_HOLD_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] POR_END = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] STG_END = CW'(STAGE_CYCLES - 1);
  localparam logic [CW-1:0] SW_END  = CW'(SW_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD,
    STAGGER,
    RUN,
    SW_HOLD
  } state_t;

  state_t                 state;
  state_t                 state_d;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_d;
  logic [CW-1:0]          cnt_inc;
  logic [N_CH-1:0]        out_d;
  logic                   ready_d;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rst_sync;
  logic [N_CH:0]          shifted;
  logic [N_CH-1:0]        next_out;
  logic                   last;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) sync <= '0;
    else         sync <= {sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_sync = sync[SYNC_STAGES-1];

  // Releases shift ones in from bit 0, so order is always ascending.
  assign shifted  = {rst_out, 1'b1};
  assign next_out = shifted[N_CH-1:0];
  assign last     = &next_out;
  assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state   <= HOLD;
      cnt     <= '0;
      rst_out <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      rst_out <= out_d;
      ready   <= ready_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    out_d   = rst_out;
    ready_d = ready;
    unique case (state)
      HOLD: begin
        if (rst_sync) begin
          if (cnt == POR_END) begin
            out_d   = N_CH'(1);
            cnt_d   = '0;
            state_d = (N_CH == 1) ? RUN : STAGGER;
            ready_d = (N_CH == 1);
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      STAGGER: begin
        if (sw_rst_req) begin
          out_d   = '0;
          ready_d = 1'b0;
          cnt_d   = '0;
          state_d = SW_HOLD;
        end else if (cnt == STG_END) begin
          out_d = next_out;
          cnt_d = '0;
          if (last) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RUN: begin
        if (sw_rst_req) begin
          out_d   = '0;
          ready_d = 1'b0;
          cnt_d   = '0;
          state_d = SW_HOLD;
        end
      end
      SW_HOLD: begin
        // Any high sample restarts the hold window.
        if (sw_rst_req) begin
          cnt_d = '0;
        end else if (cnt == SW_END) begin
          out_d   = N_CH'(1);
          cnt_d   = '0;
          state_d = (N_CH == 1) ? RUN : STAGGER;
          ready_d = (N_CH == 1);
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expected outputs are queued
// with their target cycle and compared on the falling clock edge.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_in;
  logic       sw_rst_req;
  logic [2:0] rst_out;
  logic       ready;
  logic       rst_in1;
  logic       sw1;
  logic [0:0] rst_out1;
  logic       ready1;

  always #5 clk = ~clk;

  reset_sequencer u0 (
    .clk        (clk),
    .rst_in     (rst_in),
    .sw_rst_req (sw_rst_req),
    .rst_out    (rst_out),
    .ready      (ready)
  );

  reset_sequencer #(
    .N_CH         (1),
    .POR_CYCLES   (4),
    .STAGE_CYCLES (1),
    .SYNC_STAGES  (3)
  ) u1 (
    .clk        (clk),
    .rst_in     (rst_in1),
    .sw_rst_req (sw1),
    .rst_out    (rst_out1),
    .ready      (ready1)
  );

  typedef struct {
    int         at;
    int         unit;
    logic [2:0] out;
    logic       rdy;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   t0;
  int   t0n;
  int   s;
  int   c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [3:0] obs,
                       logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic push(int at, int unit, logic [2:0] out,
                      logic rdy, string tag);
    exp_t e;
    e.at   = at;
    e.unit = unit;
    e.out  = out;
    e.rdy  = rdy;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic at_cyc(int n);
    while (cyc < n) @(negedge clk);
    #1;
  endtask

  exp_t       cur;
  logic [3:0] obs;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      cur = sb.pop_front();
      if (cur.unit == 0) obs = {rst_out, ready};
      else               obs = {2'b00, rst_out1, ready1};
      if (cur.at < cyc) begin
        checks++;
        failures++;
        $error("FAIL %s missed cyc=%0d due=%0d",
               cur.tag, cyc, cur.at);
      end else begin
        check(cur.tag, obs, {cur.out, cur.rdy});
      end
    end
  end

  initial begin
    rst_in     = 1'b0;
    sw_rst_req = 1'b0;
    rst_in1    = 1'b0;
    sw1        = 1'b0;

    at_cyc(2);
    check("por_reset_u0", {rst_out, ready}, 4'b0000);
    check("por_reset_u1", {2'b00, rst_out1, ready1}, 4'b0000);

    // Power-on sequence with a software request ignored in HOLD.
    at_cyc(3);
    rst_in = 1'b1;
    t0 = 5;
    push(t0 + 501,  0, 3'b000, 1'b0, "hold_sw_ignored");
    push(t0 + 999,  0, 3'b000, 1'b0, "por_ch0_early");
    push(t0 + 1000, 0, 3'b001, 1'b0, "por_ch0");
    push(t0 + 1015, 0, 3'b001, 1'b0, "por_ch1_early");
    push(t0 + 1016, 0, 3'b011, 1'b0, "por_ch1");
    push(t0 + 1031, 0, 3'b011, 1'b0, "por_ch2_early");
    push(t0 + 1032, 0, 3'b111, 1'b1, "por_ch2_ready");
    at_cyc(t0 + 499);
    sw_rst_req = 1'b1;
    at_cyc(t0 + 500);
    sw_rst_req = 1'b0;
    at_cyc(t0 + 1033);

    // Single-cycle software reset from RUN.
    s = cyc + 2;
    push(s - 1,  0, 3'b111, 1'b1, "run_before_sw");
    push(s,      0, 3'b000, 1'b0, "sw_assert");
    push(s + 63, 0, 3'b000, 1'b0, "sw_ch0_early");
    push(s + 64, 0, 3'b001, 1'b0, "sw_ch0");
    push(s + 79, 0, 3'b001, 1'b0, "sw_ch1_early");
    push(s + 80, 0, 3'b011, 1'b0, "sw_ch1");
    push(s + 95, 0, 3'b011, 1'b0, "sw_ch2_early");
    push(s + 96, 0, 3'b111, 1'b1, "sw_ch2_ready");
    at_cyc(s - 1);
    sw_rst_req = 1'b1;
    at_cyc(s);
    sw_rst_req = 1'b0;
    at_cyc(s + 97);

    // Held request, request in STAGGER, re-request in SW_HOLD.
    s = cyc + 2;
    push(s,      0, 3'b000, 1'b0, "long_sw_assert");
    push(s + 72, 0, 3'b000, 1'b0, "long_sw_early");
    push(s + 73, 0, 3'b001, 1'b0, "long_sw_ch0");
    at_cyc(s - 1);
    sw_rst_req = 1'b1;
    at_cyc(s + 9);
    sw_rst_req = 1'b0;
    push(s + 79, 0, 3'b001, 1'b0, "stagger_before_sw");
    push(s + 80, 0, 3'b000, 1'b0, "sw_in_stagger");
    at_cyc(s + 79);
    sw_rst_req = 1'b1;
    at_cyc(s + 80);
    sw_rst_req = 1'b0;
    push(s + 144, 0, 3'b000, 1'b0, "swhold_extended");
    push(s + 173, 0, 3'b000, 1'b0, "ext_ch0_early");
    push(s + 174, 0, 3'b001, 1'b0, "ext_ch0");
    push(s + 190, 0, 3'b011, 1'b0, "ext_ch1");
    push(s + 206, 0, 3'b111, 1'b1, "ext_ch2_ready");
    at_cyc(s + 109);
    sw_rst_req = 1'b1;
    at_cyc(s + 110);
    sw_rst_req = 1'b0;
    at_cyc(s + 207);

    // Async assertion from RUN, then a 3 ns pulse mid-STAGGER.
    c = cyc + 1;
    at_cyc(c);
    rst_in = 1'b0;
    #1;
    check("async_from_run", {rst_out, ready}, 4'b0000);
    rst_in = 1'b1;
    t0 = c + 2;
    push(t0 + 1000, 0, 3'b001, 1'b0, "restart_ch0");
    push(t0 + 1007, 0, 3'b001, 1'b0, "pre_pulse");
    at_cyc(t0 + 1008);
    rst_in = 1'b0;
    #1;
    check("async_pulse", {rst_out, ready}, 4'b0000);
    #2;
    rst_in = 1'b1;
    t0n = t0 + 1010;
    push(t0n + 999,  0, 3'b000, 1'b0, "pulse_ch0_early");
    push(t0n + 1000, 0, 3'b001, 1'b0, "pulse_ch0");
    push(t0n + 1032, 0, 3'b111, 1'b1, "pulse_ready");
    at_cyc(t0n + 1033);

    // Single-channel instance with a 3-deep synchronizer.
    c = cyc + 1;
    at_cyc(c);
    rst_in1 = 1'b1;
    push(c + 6,  1, 3'b000, 1'b0, "n1_early");
    push(c + 7,  1, 3'b001, 1'b1, "n1_release");
    push(c + 10, 1, 3'b000, 1'b0, "n1_sw_assert");
    push(c + 73, 1, 3'b000, 1'b0, "n1_sw_early");
    push(c + 74, 1, 3'b001, 1'b1, "n1_sw_release");
    at_cyc(c + 9);
    sw1 = 1'b1;
    at_cyc(c + 10);
    sw1 = 1'b0;
    at_cyc(c + 75);

    for (int i = 0; i < 20 && sb.size() > 0; i++)
      @(negedge clk);
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL drain pending=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter POR_CYCLES, default 1000, is the hold time in clk cycles after synchronized reset release; legal range >= 1.
REQ-002 Parameter N_CH, default 3, is the number of sequenced reset channels; legal range >= 1.
REQ-003 Parameter STAGE_CYCLES, default 16, is the clk-cycle gap between consecutive channel releases; legal range >= 1.
REQ-004 Parameter SW_HOLD_CYCLES, default 64, is the hold time in clk cycles after a software reset request; legal range >= 1.
REQ-005 Parameter SYNC_STAGES, default 2, is the reset-release synchronizer depth; legal range >= 2.
REQ-006 Port clk, input, 1 bit: the single clock.
REQ-007 Port rst_in, input, 1 bit: reset, asynchronous, active-low.
REQ-008 Port sw_rst_req, input, 1 bit: software reset request, synchronous to clk, active-high level.
REQ-009 Port rst_out, output, N_CH bits: per-channel reset, active-low; bit k is channel k.
REQ-010 Port ready, output, 1 bit: high when all channels are released.

Function
REQ-011 Async assert, sync release: a SYNC_STAGES-deep flop chain is cleared asynchronously by rst_in low and shifts in 1 when rst_in is high.
REQ-012 T0 = the clk edge at which the last synchronizer flop first becomes 1, i.e. SYNC_STAGES-1 edges after the first edge sampling rst_in high.
REQ-013 States: HOLD (POR count), STAGGER (channel release), RUN (all released), SW_HOLD (software reset hold).
REQ-014 HOLD: the cycle counter increments every edge after T0; rst_out[0] goes high at edge T0+POR_CYCLES; state then moves to STAGGER, or to RUN if N_CH = 1.
REQ-015 STAGGER: rst_out[k] goes high STAGE_CYCLES edges after rst_out[k-1]; on the edge that releases rst_out[N_CH-1], state moves to RUN.
REQ-016 ready is registered and rises on the same edge as rst_out[N_CH-1]; it is high only in RUN.
REQ-017 A released channel stays released until a reset event; release order is always ascending k.
REQ-018 sw_rst_req sampled high in STAGGER or RUN at edge E: on E, rst_out = all 0, ready = 0, counter = 0, state = SW_HOLD.
REQ-019 SW_HOLD: every edge with sw_rst_req high clears the counter. rst_out[0] releases SW_HOLD_CYCLES edges after the last high sample, then STAGGER proceeds as in REQ-015.
REQ-020 sw_rst_req is ignored in HOLD; the POR sequence is neither extended nor restarted.
REQ-021 Counter width = $clog2(max(POR_CYCLES, STAGE_CYCLES, SW_HOLD_CYCLES)+1); the counter saturates and never wraps.
REQ-022 All outputs are driven directly from flops; there is no combinational path from inputs to outputs other than the asynchronous reset.

Reset
REQ-023 rst_in low asynchronously forces rst_out = all 0, ready = 0, state = HOLD, counter = 0, synchronizer = all 0, within the same delta, independent of clk.
REQ-024 A rst_in low pulse of any width, including less than one clk period and including mid-STAGGER or mid-SW_HOLD, restarts the full sequence from REQ-012.
REQ-025 No output glitches high during rst_in assertion or release; release occurs only on clk edges.

Verification
REQ-026 Defaults; rst_in rises before edge E1 -> T0 = E1+1; rst_out 001 at T0+1000, 011 at T0+1016, 111 with ready = 1 at T0+1032.
REQ-027 Defaults; rst_in driven low at T0+1008 for 3 ns mid-cycle -> rst_out = 000 and ready = 0 immediately; after re-release, rst_out[0] rises at new T0+1000.
REQ-028 Defaults, in RUN; sw_rst_req high for 1 cycle at edge S -> rst_out = 000 after S; 001 at S+64, 011 at S+80, 111 with ready = 1 at S+96.
REQ-029 Defaults; sw_rst_req held high for edges S..S+9 -> rst_out[0] releases at S+9+64; a further pulse during SW_HOLD extends the release again.
REQ-030 Defaults; sw_rst_req pulsed at T0+500 (HOLD) -> no effect; rst_out[0] still releases at T0+1000.
REQ-031 N_CH=1, POR_CYCLES=4, STAGE_CYCLES=1, SYNC_STAGES=3 -> T0 = E1+2; rst_out[0] and ready both rise at T0+4.
